// File: rtl/axil_mem_master_if.sv
// AXI4-Lite bus bundle between the memory master and its slave.
// The master modport drives address, data, strobes and the response readies.
interface axil_mem_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_mem_master.sv
// Bridges a simple valid/ready CPU port to single AXI4-Lite transactions,
// one outstanding at a time, with a one-cycle completion pulse.
//
// state | meaning
// IDLE  | waiting for cpu_valid (skipped for one cycle right after DONE)
// WADDR | AW and W offered together, each retired on its own handshake
// WRESP | bready high, waiting for the write response
// RADDR | arvalid high, waiting for arready
// RDATA | rready high, waiting for read data
// DONE  | cpu_ready pulse with rdata/err
module axil_mem_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_valid,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [STRB_WIDTH-1:0] cpu_wstrb,
    output logic                  cpu_ready,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_err,
    axil_mem_master_if.master     axi
);
    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  aw_done;
    logic                  w_done;
    logic                  cool;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  resp_lsb_unused;

    assign axi.awaddr  = addr_q;
    assign axi.araddr  = addr_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign aw_fire = awvalid_q & axi.awready;
    assign w_fire  = wvalid_q & axi.wready;

    // Only bit 1 of a response distinguishes OKAY from SLVERR/DECERR.
    assign resp_lsb_unused = axi.bresp[0] ^ axi.rresp[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            cool      <= 1'b0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    cool <= 1'b0;
                    if (cpu_valid && !cool) begin
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        wstrb_q <= cpu_wstrb;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (cpu_wstrb != '0) begin
                            state     <= WADDR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state     <= RADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                WADDR: begin
                    if (aw_fire) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        state    <= WRESP;
                        bready_q <= 1'b1;
                    end
                end
                WRESP: begin
                    if (axi.bvalid) begin
                        bready_q  <= 1'b0;
                        cpu_err   <= axi.bresp[1];
                        cpu_rdata <= '0;
                        cpu_ready <= 1'b1;
                        state     <= DONE;
                    end
                end
                RADDR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RDATA;
                    end
                end
                RDATA: begin
                    if (axi.rvalid) begin
                        rready_q  <= 1'b0;
                        cpu_err   <= axi.rresp[1];
                        cpu_rdata <= axi.rresp[1] ? '0 : axi.rdata;
                        cpu_ready <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Blocks acceptance in the IDLE cycle that follows.
                    cool  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/axil_mem_master.md
AXIL_MEM_MASTER -- requirements
Module: axil_mem_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32, address width in bits.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8, byte-strobe width.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 cpu_valid  input  1  CPU request valid; held high until cpu_ready.
REQ-007 cpu_addr  input  ADDR_WIDTH  request byte address.
REQ-008 cpu_wdata  input  DATA_WIDTH  write data.
REQ-009 cpu_wstrb  input  STRB_WIDTH  byte enables; all-zero means read, non-zero means write.
REQ-010 cpu_ready  output  1  one-cycle completion pulse.
REQ-011 cpu_rdata  output  DATA_WIDTH  read data, valid with cpu_ready.
REQ-012 cpu_err  output  1  completion carried SLVERR/DECERR, valid with cpu_ready.
REQ-013 axi_awaddr/axi_awvalid out, axi_awready in: AXI-Lite write address channel, ADDR_WIDTH/1/1.
REQ-014 axi_wdata/axi_wstrb/axi_wvalid out, axi_wready in: write data channel, DATA_WIDTH/STRB_WIDTH/1/1.
REQ-015 axi_bresp in (2), axi_bvalid in (1), axi_bready out (1): write response channel.
REQ-016 axi_araddr/axi_arvalid out, axi_arready in: read address channel, ADDR_WIDTH/1/1.
REQ-017 axi_rdata in (DATA_WIDTH), axi_rresp in (2), axi_rvalid in (1), axi_rready out (1): read data channel.

Function
REQ-018 The FSM SHALL have states IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
REQ-019 In IDLE with cpu_valid=1, the block SHALL register cpu_addr, cpu_wdata and cpu_wstrb and go to WADDR if cpu_wstrb!=0, else RADDR.
REQ-020 All AXI address/data/strobe outputs SHALL come from the registered copies; CPU input changes after acceptance SHALL have no effect.
REQ-021 On entering WADDR, axi_awvalid and axi_wvalid SHALL both assert in the same cycle.
REQ-022 Each of awvalid and wvalid SHALL deassert the cycle after its own handshake; the two handshakes may complete in the same or different cycles, in either order.
REQ-023 Once both the AW and W handshakes are complete, the FSM SHALL go to WRESP.
REQ-024 In WRESP, axi_bready SHALL be 1; on bvalid&bready, the block SHALL capture bresp[1] as the error flag and go to DONE.
REQ-025 In RADDR, axi_arvalid SHALL be 1; on arvalid&arready, the FSM SHALL go to RDATA.
REQ-026 The block SHALL tolerate arready asserted before arvalid and SHALL NOT wait for arready to fall.
REQ-027 In RDATA, axi_rready SHALL be 1; on rvalid&rready, the block SHALL capture rdata and rresp[1] and go to DONE.
REQ-028 In DONE, cpu_ready SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-029 cpu_rdata SHALL be the captured rdata for a read; it SHALL be 0 for a write or for any errored completion.
REQ-030 A new request SHALL NOT be accepted in DONE or in the IDLE cycle being entered from DONE; the earliest next acceptance is the second cycle after cpu_ready.
REQ-031 At most one AXI transaction SHALL be outstanding; a valid, once asserted, SHALL NOT deassert before its handshake.
REQ-032 axi_bready SHALL be 0 outside WRESP and axi_rready SHALL be 0 outside RDATA; a stray bvalid/rvalid SHALL be ignored.
REQ-033 Minimum latency with zero-wait slave: write 4 cycles (accept, AW/W, B, DONE); read 4 cycles (accept, AR, R, DONE).

Reset
REQ-034 While rst_n=0, the FSM SHALL be IDLE and all valid/ready outputs and cpu_err SHALL be 0.
REQ-035 While rst_n=0, cpu_rdata and the registered address/data/strobe SHALL be 0.
REQ-036 Reset asserted mid-transaction SHALL abandon the transaction without producing a cpu_ready.

Verification
REQ-037 Write 0xDEADBEEF to 0x400 with wstrb=0xF, slave AW/W/B zero-wait -> one cpu_ready, cpu_err=0, cpu_rdata=0.
REQ-038 Read 0x404, arready high before arvalid, rvalid 3 cycles later with rdata=0x12345678, rresp=0 -> cpu_rdata=0x12345678, cpu_err=0.
REQ-039 Write with awready 2 cycles before wready -> awvalid drops 1 cycle after its handshake, wvalid holds until its own, and exactly one AW and one W beat occur.
REQ-040 Read 0x2000 with rresp=2'b10 -> cpu_err=1, cpu_rdata=0.
REQ-041 Back-to-back requests with cpu_valid held continuously -> second acceptance no earlier than 2 cycles after the first cpu_ready, and no duplicate AXI transaction.
REQ-042 rst_n pulsed low during RDATA -> all outputs 0 next cycle, no cpu_ready, and the next request is handled normally.
